// File: rtl/axi_write_burst_multi.sv
// AXI4 write master: drains an AXI4-Stream into memory as INCR bursts capped at
// C_MAX_BURST_LEN beats that never cross a 4 KB boundary; checks B responses and tlast framing.
module axi_write_burst_multi #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_MAX_BURST_LEN    = 16,
    parameter int C_LEN_WIDTH        = 16
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_aresetn,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awlock,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    input  logic                              run,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     start_addr,
    input  logic [C_LEN_WIDTH-1:0]            byte_length,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        error,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SZ = $clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam int CW = (C_LEN_WIDTH > 13) ? C_LEN_WIDTH : 13;
    localparam logic [AW-1:0]          LOW_MASK = AW'((C_M_AXI_DATA_WIDTH / 8) - 1);
    localparam logic [C_LEN_WIDTH-1:0] LEN_ONE  = C_LEN_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

    state_t                  state_reg, state_next;
    logic [AW-1:0]           addr_reg;
    logic [C_LEN_WIDTH-1:0]  remaining_reg;
    logic [C_LEN_WIDTH-1:0]  beat_cnt_reg;
    logic [CW-1:0]           burst_len_reg;
    logic [1:0]              error_reg;

    logic [C_LEN_WIDTH-1:0]  run_beats;
    logic [12:0]             room_bytes;
    logic [CW-1:0]           rem_ext, room_ext, max_ext, blen_ext;
    logic                    aw_hs, w_hs, b_hs, last_beat;

    assign run_beats  = byte_length >> SZ;
    // Beats left before the next 4 KB page; a page-aligned address yields the full 4096 bytes.
    assign room_bytes = 13'd4096 - {1'b0, addr_reg[11:0]};
    assign rem_ext    = CW'(remaining_reg);
    assign room_ext   = CW'(room_bytes >> SZ);
    assign max_ext    = CW'(C_MAX_BURST_LEN);

    always_comb begin
        blen_ext = rem_ext;
        if (max_ext < blen_ext)  blen_ext = max_ext;
        if (room_ext < blen_ext) blen_ext = room_ext;
    end

    assign last_beat = (beat_cnt_reg == LEN_ONE);
    assign aw_hs     = (state_reg == S_ADDR) && m_axi_awready;
    assign w_hs      = (state_reg == S_DATA) && s_axis_tvalid && m_axi_wready;
    assign b_hs      = (state_reg == S_RESP) && m_axi_bvalid;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) state_reg <= S_IDLE;
        else                state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (run) state_next = (run_beats != '0) ? S_ADDR : S_FIN;
            S_ADDR: if (m_axi_awready) state_next = S_DATA;
            S_DATA: if (w_hs && last_beat) state_next = S_RESP;
            S_RESP: if (m_axi_bvalid) state_next = (remaining_reg != '0) ? S_ADDR : S_FIN;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_awlen   = 8'd0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        s_axis_tready = 1'b0;
        m_axi_bready  = 1'b0;
        busy          = (state_reg != S_IDLE);
        done          = 1'b0;
        case (state_reg)
            S_ADDR: begin
                m_axi_awvalid = 1'b1;
                m_axi_awlen   = 8'(blen_ext - CW'(1));
            end
            S_DATA: begin
                m_axi_wvalid  = s_axis_tvalid;
                s_axis_tready = m_axi_wready;
                m_axi_wlast   = last_beat;
            end
            S_RESP:  m_axi_bready = 1'b1;
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            beat_cnt_reg  <= '0;
            burst_len_reg <= '0;
            error_reg     <= 2'b00;
        end else begin
            if (state_reg == S_IDLE && run) begin
                addr_reg      <= start_addr & ~LOW_MASK;
                remaining_reg <= run_beats;
                error_reg     <= 2'b00;
            end
            if (aw_hs) begin
                beat_cnt_reg  <= C_LEN_WIDTH'(blen_ext);
                burst_len_reg <= blen_ext;
            end
            if (w_hs) begin
                beat_cnt_reg  <= beat_cnt_reg - LEN_ONE;
                remaining_reg <= remaining_reg - LEN_ONE;
                // tlast must coincide exactly with the final beat of the whole transfer.
                if (s_axis_tlast != (remaining_reg == LEN_ONE)) error_reg[1] <= 1'b1;
                if (last_beat) addr_reg <= addr_reg + (AW'(burst_len_reg) << SZ);
            end
            if (b_hs && m_axi_bresp != 2'b00) error_reg[0] <= 1'b1;
        end
    end

    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awsize  = 3'(SZ);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign error         = error_reg;
endmodule

// File: tb/tb_axi_write_burst_multi.sv
// Bench for axi_write_burst_multi: table vectors, reset/idle sequences and random
// transfers against a burst-splitting reference model with a randomly stalling slave.
module tb_axi_write_burst_multi;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int MBL = 16;
    localparam int LW  = 16;
    localparam int NONE = 9999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize, awprot;
    logic [1:0]      awburst;
    logic            awlock, awvalid, awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast, wvalid, wready;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic            run;
    logic [AW-1:0]   start_addr;
    logic [LW-1:0]   byte_length;
    logic            busy, done;
    logic [1:0]      error;
    logic [DW-1:0]   tdata;
    logic            tvalid, tready, tlast;

    axi_write_burst_multi #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_MAX_BURST_LEN(MBL), .C_LEN_WIDTH(LW)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awprot(awprot), .m_axi_awlock(awlock),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .run(run), .start_addr(start_addr), .byte_length(byte_length),
        .busy(busy), .done(done), .error(error),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast)
    );

    typedef struct {
        logic [31:0] addr;
        int          bytes;
        int          tlast_beat;
        int          err_burst;
        bit          stall;
        int          exp_bursts;
        logic [1:0]  exp_err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave / stream-source state shared with the transfer tasks
    int          cur_beats = 0, cur_tlast = NONE, cur_err = NONE;
    bit          cur_stall = 1'b0;
    logic [31:0] tag = 32'h0;
    int          src_idx = 0, pending_b = 0, b_idx = 0, b_lat = 0, done_cnt = 0;
    bit          tv_hold = 1'b0, aw_pend_prev = 1'b0, b_drop = 1'b0;
    logic [31:0] aw_addr_prev;
    logic [7:0]  aw_len_prev;
    logic [31:0] seen_addr[$];
    int          seen_len[$];
    bit          seen_last[256];

    // Reference model output
    logic [31:0] exp_addr[$];
    int          exp_len[$];
    bit          exp_last[256];

    task automatic clear_model();
        cur_beats = 0; cur_tlast = NONE; cur_err = NONE; cur_stall = 1'b0;
        src_idx = 0; pending_b = 0; b_idx = 0; b_lat = 0; done_cnt = 0;
        tv_hold = 1'b0; aw_pend_prev = 1'b0; b_drop = 1'b0;
        seen_addr.delete(); seen_len.delete();
        for (int i = 0; i < 256; i++) seen_last[i] = 1'b0;
    endtask

    // Split a transfer into bursts by plain arithmetic: page room, burst cap, what is left.
    task automatic build_model(input logic [31:0] addr, input int beats);
        longint a;
        int rem, room, len, pos;
        exp_addr.delete(); exp_len.delete();
        for (int i = 0; i < 256; i++) exp_last[i] = 1'b0;
        a = longint'(addr) / 8 * 8;
        rem = beats;
        pos = 0;
        while (rem > 0) begin
            room = int'((4096 - (a % 4096)) / 8);
            len = rem;
            if (len > MBL) len = MBL;
            if (len > room) len = room;
            exp_addr.push_back(32'(a));
            exp_len.push_back(len);
            pos += len;
            if (pos - 1 < 256) exp_last[pos - 1] = 1'b1;
            a = (a + len * 8) % 64'h1_0000_0000;
            rem -= len;
        end
    endtask

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; tvalid = 1'b0;
                continue;
            end
            if (b_drop) begin bvalid = 1'b0; b_drop = 1'b0; end
            awready = cur_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            wready  = cur_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            tvalid  = (src_idx < cur_beats) &&
                      (tv_hold || !cur_stall || ($urandom_range(0, 3) != 0));
            tdata   = {tag, 32'(src_idx)};
            tlast   = (src_idx == cur_tlast);
            if (!bvalid && pending_b > 0) begin
                if (b_lat == 0) begin
                    bvalid = 1'b1;
                    bresp  = (b_idx == cur_err) ? 2'b10 : 2'b00;
                end else b_lat--;
            end
            #1;
            if (awvalid) begin
                if (aw_pend_prev) begin
                    check("aw_hold_addr", 64'(awaddr), 64'(aw_addr_prev));
                    check("aw_hold_len", 64'(awlen), 64'(aw_len_prev));
                end
                if (awready) begin
                    seen_addr.push_back(awaddr);
                    seen_len.push_back(int'(awlen) + 1);
                    aw_pend_prev = 1'b0;
                end else begin
                    aw_pend_prev = 1'b1;
                    aw_addr_prev = awaddr;
                    aw_len_prev  = awlen;
                end
            end
            if (wvalid && wready) begin
                check("wdata", 64'(wdata), {tag, 32'(src_idx)});
                if (src_idx < 256) seen_last[src_idx] = wlast;
                src_idx++;
                if (wlast) pending_b++;
                tv_hold = 1'b0;
            end else tv_hold = tvalid;
            if (bvalid && bready) begin
                b_idx++;
                pending_b--;
                b_drop = 1'b1;
                b_lat = cur_stall ? int'($urandom_range(0, 3)) : 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_transfer(input vec_t v, input string nm);
        int beats, cyc, bad;
        beats = v.bytes / 8;
        @(negedge clk);
        #3;
        clear_model();
        build_model(v.addr, beats);
        cur_beats = beats; cur_tlast = v.tlast_beat; cur_err = v.err_burst;
        cur_stall = v.stall; tag = $urandom;
        @(negedge clk);
        run = 1'b1; start_addr = v.addr; byte_length = LW'(v.bytes);
        @(negedge clk);
        run = 1'b0; start_addr = $urandom; byte_length = LW'($urandom);
        #2;
        check({nm, "_busy_start"}, 64'(busy), 64'(1));
        check({nm, "_awvalid_start"}, 64'(awvalid), 64'(beats > 0));
        check({nm, "_error_cleared"}, 64'(error), 64'(0));
        for (cyc = 0; cyc < 4000 && done_cnt == 0; cyc++) begin
            @(negedge clk);
            #2;
        end
        if (done_cnt == 0) begin
            check({nm, "_done_timeout"}, 64'(0), 64'(1));
            return;
        end
        check({nm, "_error"}, 64'(error), 64'(v.exp_err));
        @(negedge clk);
        #2;
        check({nm, "_busy_end"}, 64'(busy), 64'(0));
        check({nm, "_done_pulses"}, 64'(done_cnt), 64'(1));
        check({nm, "_aw_count"}, 64'(seen_addr.size()), 64'(v.exp_bursts));
        check({nm, "_aw_model_count"}, 64'(seen_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < seen_addr.size(); i++) begin
            check({nm, "_awaddr"}, 64'(seen_addr[i]), 64'(exp_addr[i]));
            check({nm, "_awlen"}, 64'(seen_len[i]), 64'(exp_len[i]));
        end
        check({nm, "_beats"}, 64'(src_idx), 64'(beats));
        bad = 0;
        for (int i = 0; i < beats && i < 256; i++)
            if (seen_last[i] != exp_last[i]) bad++;
        check({nm, "_wlast_pattern_errs"}, 64'(bad), 64'(0));
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        int beats, nb;
        run = 1'b0; start_addr = '0; byte_length = '0;
        vecs[0] = '{32'h1000, 128, 15,   NONE, 1'b0, 1, 2'b00};
        vecs[1] = '{32'h1000, 320, 39,   NONE, 1'b0, 3, 2'b00};
        vecs[2] = '{32'h0FF0, 64,  7,    NONE, 1'b0, 2, 2'b00};
        vecs[3] = '{32'h1000, 320, 39,   1,    1'b0, 3, 2'b01};
        vecs[4] = '{32'h1000, 128, 4,    NONE, 1'b0, 1, 2'b10};
        vecs[5] = '{32'h1000, 7,   NONE, NONE, 1'b0, 0, 2'b00};
        vecs[6] = '{32'h0FF3, 64,  7,    NONE, 1'b1, 2, 2'b00};
        vecs[7] = '{32'h1FF8, 24,  NONE, NONE, 1'b1, 2, 2'b10};
        vecs[8] = '{32'h1000, 320, 39,   2,    1'b1, 3, 2'b01};

        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_awvalid", 64'(awvalid), 64'(0));
        check("rst_awaddr", 64'(awaddr), 64'(0));
        check("rst_awlen", 64'(awlen), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("const_awsize", 64'(awsize), 64'(3));
        check("const_awburst", 64'(awburst), 64'(1));
        check("const_wstrb", 64'(wstrb), 64'(8'hFF));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_transfer(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a burst, then a clean restart
        @(negedge clk);
        #3;
        clear_model();
        build_model(32'h1000, 16);
        cur_beats = 16; cur_tlast = 4; tag = 32'hDEAD0001;
        @(negedge clk);
        run = 1'b1; start_addr = 32'h1000; byte_length = 16'd128;
        @(negedge clk);
        run = 1'b0;
        for (int c = 0; c < 200 && src_idx < 6; c++) @(negedge clk);
        check("rst_mid_reached_data", 64'(src_idx >= 6), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_awvalid", 64'(awvalid), 64'(0));
        check("rstmid_wvalid", 64'(wvalid), 64'(0));
        check("rstmid_wlast", 64'(wlast), 64'(0));
        check("rstmid_bready", 64'(bready), 64'(0));
        check("rstmid_tready", 64'(tready), 64'(0));
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_done", 64'(done), 64'(0));
        check("rstmid_awaddr", 64'(awaddr), 64'(0));
        check("rstmid_awlen", 64'(awlen), 64'(0));
        check("rstmid_error", 64'(error), 64'(0));
        @(negedge clk);
        #3;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        run_transfer(vecs[1], "after_rst");

        // Randomised transfers clustered around 4 KB page ends
        for (int t = 0; t < 25; t++) begin
            rv.addr  = 32'($urandom_range(1, 15)) * 32'h2000 - 32'(8 * $urandom_range(0, 40))
                       + 32'($urandom_range(0, 7));
            rv.bytes = int'($urandom_range(0, 700));
            beats    = rv.bytes / 8;
            rv.tlast_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 90)) : beats - 1;
            rv.err_burst  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : NONE;
            rv.stall = 1'b1;
            build_model(rv.addr, beats);
            nb = exp_addr.size();
            rv.exp_bursts = nb;
            rv.exp_err[0] = (rv.err_burst < nb);
            rv.exp_err[1] = (beats > 0) && (rv.tlast_beat != beats - 1);
            run_transfer(rv, $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
